round_sequencer: RTL and testbench



---
 rtl/round_pkg.sv | 20 ++
 rtl/sec_tick_gen.sv | 32 +++
 rtl/round_sequencer.sv | 177 +++++++++++++++++
 tb/tb_round_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/round_pkg.sv
// Purpose : shared phase encodings and field widths for the round sequencer and display path.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: PH_* phase codes, SCORE_W, SECONDS_W, phase_e state type.
package round_pkg;
    localparam logic [1:0] PH_IDLE      = 2'd0;
    localparam logic [1:0] PH_COUNTDOWN = 2'd1;
    localparam logic [1:0] PH_RUN       = 2'd2;
    localparam logic [1:0] PH_GAMEOVER  = 2'd3;

    localparam int SCORE_W   = 8;
    localparam int SECONDS_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = PH_IDLE,
        ST_COUNTDOWN = PH_COUNTDOWN,
        ST_RUN       = PH_RUN,
        ST_GAMEOVER  = PH_GAMEOVER
    } phase_e;
endpackage

// File: rtl/sec_tick_gen.sv
// Purpose : one-second prescaler; tick is high for one cycle when the count reaches CLK_HZ-1.
// Latency : tick is combinational from the count; clear takes effect on the next edge (count=0).
// Backpressure: none; free-running unless cleared.
// Ports   : clk, rst_n (async active-low), clear (restart count at 0), tick (1-cycle pulse).
module sec_tick_gen #(
    parameter int CLK_HZ = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    // Keep at least one bit so CLK_HZ=1 still elaborates.
    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_MAX);
    assign tick   = w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/round_sequencer.sv
// Purpose : sequences one timed game round (idle, countdown, run, game-over hold) and owns run_enable.
// Latency : every output is registered; phase changes land on the edge that samples the cause.
// Backpressure: none; single-cycle start/abort requests are acted on or dropped in the same cycle.
// Ports   : clk, rst_n, start_edge, abort_edge, score in; run_enable, phase, seconds_left,
//           final_score, round_done, high_score, new_record out.
// Config  : define HISCORE_EN to build the session high-score tracker; otherwise high_score and
//           new_record are constant 0.
module round_sequencer
    import round_pkg::*;
#(
    parameter int CLK_HZ            = 50000000,
    parameter int COUNTDOWN_SECONDS = 3,
    parameter int ROUND_SECONDS     = 30,
    parameter int HOLD_SECONDS      = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_edge,
    input  logic                 abort_edge,
    input  logic [SCORE_W-1:0]   score,
    output logic                 run_enable,
    output logic [1:0]           phase,
    output logic [SECONDS_W-1:0] seconds_left,
    output logic [SCORE_W-1:0]   final_score,
    output logic                 round_done,
    output logic [SCORE_W-1:0]   high_score,
    output logic                 new_record
);
    localparam logic [SECONDS_W-1:0] CD_SECS    = SECONDS_W'(COUNTDOWN_SECONDS);
    localparam logic [SECONDS_W-1:0] ROUND_SECS = SECONDS_W'(ROUND_SECONDS);
    localparam logic [SECONDS_W-1:0] HOLD_SECS  = SECONDS_W'(HOLD_SECONDS);

    phase_e               r_phase, w_nxt_phase;
    logic [SECONDS_W-1:0] r_secs, w_nxt_secs;
    logic                 r_run, w_nxt_run;
    logic [SCORE_W-1:0]   r_final, w_nxt_final;
    logic                 r_done, w_nxt_done;
    logic                 w_clear;     // phase entry: restart the prescaler
    logic                 w_start_ok;  // start accepted from IDLE/GAMEOVER
    logic                 w_tick;

    sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_comb begin
        w_nxt_phase = r_phase;
        w_nxt_secs  = r_secs;
        w_nxt_run   = r_run;
        w_nxt_final = r_final;
        w_nxt_done  = 1'b0;
        w_clear     = 1'b0;
        w_start_ok  = 1'b0;
        case (r_phase)
            ST_IDLE: begin
                w_nxt_run  = 1'b0;
                w_nxt_secs = '0;
                if (start_edge) begin
                    w_nxt_phase = ST_COUNTDOWN;
                    w_nxt_secs  = CD_SECS;
                    w_clear     = 1'b1;
                    w_start_ok  = 1'b1;
                end
            end
            ST_COUNTDOWN: begin
                // Abort outranks both a coincident tick and a coincident start.
                if (abort_edge) begin
                    w_nxt_phase = ST_IDLE;
                    w_nxt_secs  = '0;
                    w_nxt_run   = 1'b0;
                    w_clear     = 1'b1;
                end else if (w_tick) begin
                    if (r_secs <= 8'd1) begin
                        w_nxt_phase = ST_RUN;
                        w_nxt_secs  = ROUND_SECS;
                        w_nxt_run   = 1'b1;
                        w_clear     = 1'b1;
                    end else begin
                        w_nxt_secs = r_secs - 8'd1;
                    end
                end
            end
            ST_RUN: begin
                if (abort_edge) begin
                    w_nxt_phase = ST_IDLE;
                    w_nxt_secs  = '0;
                    w_nxt_run   = 1'b0;
                    w_clear     = 1'b1;
                end else if (w_tick) begin
                    if (r_secs <= 8'd1) begin
                        // Score is still live this cycle; the core clears only after
                        // it sees run_enable low.
                        w_nxt_phase = ST_GAMEOVER;
                        w_nxt_secs  = HOLD_SECS;
                        w_nxt_run   = 1'b0;
                        w_nxt_final = score;
                        w_nxt_done  = 1'b1;
                        w_clear     = 1'b1;
                    end else begin
                        w_nxt_secs = r_secs - 8'd1;
                    end
                end
            end
            ST_GAMEOVER: begin
                if (start_edge) begin
                    w_nxt_phase = ST_COUNTDOWN;
                    w_nxt_secs  = CD_SECS;
                    w_clear     = 1'b1;
                    w_start_ok  = 1'b1;
                end else if (w_tick) begin
                    if (r_secs == 8'd1) begin
                        w_nxt_phase = ST_IDLE;
                        w_nxt_secs  = '0;
                        w_clear     = 1'b1;
                    end else if (r_secs != 8'd0) begin
                        w_nxt_secs = r_secs - 8'd1;
                    end
                end
            end
            default: begin
                w_nxt_phase = ST_IDLE;
                w_nxt_secs  = '0;
                w_nxt_run   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= ST_IDLE;
            r_secs  <= '0;
            r_run   <= 1'b0;
            r_final <= '0;
            r_done  <= 1'b0;
        end else begin
            r_phase <= w_nxt_phase;
            r_secs  <= w_nxt_secs;
            r_run   <= w_nxt_run;
            r_final <= w_nxt_final;
            r_done  <= w_nxt_done;
        end
    end

    assign phase        = r_phase;
    assign seconds_left = r_secs;
    assign run_enable   = r_run;
    assign final_score  = r_final;
    assign round_done   = r_done;

`ifdef HISCORE_EN
    logic [SCORE_W-1:0] r_high;
    logic               r_new;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_high <= '0;
            r_new  <= 1'b0;
        end else if (w_nxt_done) begin
            if (score > r_high) begin
                r_high <= score;
                r_new  <= 1'b1;
            end
        end else if (w_start_ok) begin
            r_new <= 1'b0;
        end
    end

    assign high_score = r_high;
    assign new_record = r_new;
`else
    assign high_score = '0;
    assign new_record = 1'b0;
`endif
endmodule

// File: tb/tb_round_sequencer.sv
module tb_round_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_edge = 1'b0;
    logic       abort_edge = 1'b0;
    logic [7:0] score = 8'd7;
    logic       run_enable;
    logic [1:0] phase;
    logic [7:0] seconds_left;
    logic [7:0] final_score;
    logic       round_done;
    logic [7:0] high_score;
    logic       new_record;

    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    round_sequencer #(
        .CLK_HZ(10), .COUNTDOWN_SECONDS(3), .ROUND_SECONDS(5), .HOLD_SECONDS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_edge(start_edge), .abort_edge(abort_edge),
        .score(score), .run_enable(run_enable), .phase(phase), .seconds_left(seconds_left),
        .final_score(final_score), .round_done(round_done), .high_score(high_score),
        .new_record(new_record)
    );

    // Count round_done pulses, sampled away from the active edge.
    always @(negedge clk) if (round_done) n_done <= n_done + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the next negedge with the edge's result visible.
    task automatic pulse(input logic s, input logic a);
        start_edge = s;
        abort_edge = a;
        @(negedge clk);
        start_edge = 1'b0;
        abort_edge = 1'b0;
    endtask

    // From IDLE/GAMEOVER: start and walk through the countdown to the RUN entry cycle.
    task automatic to_run();
        pulse(1'b1, 1'b0);
        wait_cyc(30);
    endtask

    // From the RUN entry cycle: present v only in the cycle of the final tick.
    task automatic finish_round(input logic [7:0] v);
        wait_cyc(49);
        score = v;
        @(negedge clk);
        score = 8'd7;
    endtask

    int d0;

    initial begin
        wait_cyc(2);
        chk("rst_phase", phase, 0);
        chk("rst_run", run_enable, 0);
        chk("rst_secs", seconds_left, 0);
        chk("rst_final", final_score, 0);
        chk("rst_done", round_done, 0);
        chk("rst_high", high_score, 0);
        chk("rst_newrec", new_record, 0);
        rst_n = 1'b1;

        // Full round.
        wait_cyc(5);
        pulse(1'b1, 1'b0);
        chk("cd_phase", phase, 1);
        chk("cd_secs3", seconds_left, 3);
        chk("cd_run", run_enable, 0);
        wait_cyc(9);
        chk("cd_secs3_end", seconds_left, 3);
        wait_cyc(1);
        chk("cd_secs2", seconds_left, 2);
        wait_cyc(10);
        chk("cd_secs1", seconds_left, 1);
        wait_cyc(10);
        chk("run_phase", phase, 2);
        chk("run_secs5", seconds_left, 5);
        chk("run_en", run_enable, 1);
        wait_cyc(40);
        chk("run_secs1", seconds_left, 1);
        chk("run_en_late", run_enable, 1);
        wait_cyc(9);
        score = 8'd42;
        @(negedge clk);
        score = 8'd7;
        chk("go_phase", phase, 3);
        chk("go_secs", seconds_left, 2);
        chk("go_run", run_enable, 0);
        chk("go_final", final_score, 42);
        chk("go_done", round_done, 1);
        wait_cyc(1);
        chk("go_done_1cyc", round_done, 0);
        chk("go_final_hold", final_score, 42);
        wait_cyc(18);
        chk("go_secs1", seconds_left, 1);
        chk("go_still", phase, 3);
        wait_cyc(1);
        chk("idle_phase", phase, 0);
        chk("idle_secs", seconds_left, 0);

        // Abort in the 12th cycle of RUN.
        to_run();
        wait_cyc(11);
        d0 = n_done;
        pulse(1'b0, 1'b1);
        chk("abort_phase", phase, 0);
        chk("abort_run", run_enable, 0);
        chk("abort_secs", seconds_left, 0);
        chk("abort_final", final_score, 42);
        wait_cyc(2);
        chk("abort_nodone", n_done - d0, 0);

        // Abort while idle is ignored; start during RUN is ignored.
        pulse(1'b0, 1'b1);
        chk("abort_idle", phase, 0);
        to_run();
        wait_cyc(3);
        pulse(1'b1, 1'b0);
        chk("start_in_run", phase, 2);
        chk("start_in_run_secs", seconds_left, 5);
        // Start+abort together in RUN: abort wins.
        pulse(1'b1, 1'b1);
        chk("both_run_phase", phase, 0);
        chk("both_run_en", run_enable, 0);

        // Start+abort together in GAMEOVER: start wins.
        to_run();
        finish_round(8'd9);
        chk("r2_final", final_score, 9);
        pulse(1'b1, 1'b1);
        chk("both_go_phase", phase, 1);
        chk("both_go_secs", seconds_left, 3);

        // Restart 3 cycles into the hold: prescaler restarts from zero.
        wait_cyc(30);
        finish_round(8'd11);
        chk("r3_phase", phase, 3);
        wait_cyc(2);
        pulse(1'b1, 1'b0);
        chk("restart_phase", phase, 1);
        chk("restart_secs", seconds_left, 3);
        wait_cyc(9);
        chk("restart_secs_hold", seconds_left, 3);
        wait_cyc(1);
        chk("restart_tick", seconds_left, 2);

        // Asynchronous reset mid-RUN, between edges.
        wait_cyc(20);
        chk("pre_rst_run", run_enable, 1);
        wait_cyc(5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_run", run_enable, 0);
        chk("arst_phase", phase, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(1);
        chk("post_rst_secs", seconds_left, 0);
        chk("post_rst_final", final_score, 0);
        chk("post_rst_done", round_done, 0);
        chk("post_rst_high", high_score, 0);
        chk("post_rst_new", new_record, 0);

        // High-score sequence 20, 35, 30 from a clean reset.
        to_run();
        finish_round(8'd20);
        chk("hs1_final", final_score, 20);
`ifdef HISCORE_EN
        chk("hs1_high", high_score, 20);
        chk("hs1_new", new_record, 1);
`else
        chk("hs1_high", high_score, 0);
        chk("hs1_new", new_record, 0);
`endif
        pulse(1'b1, 1'b0);
        chk("hs_clr_new", new_record, 0);
        wait_cyc(30);
        finish_round(8'd35);
        chk("hs2_final", final_score, 35);
`ifdef HISCORE_EN
        chk("hs2_high", high_score, 35);
        chk("hs2_new", new_record, 1);
`else
        chk("hs2_high", high_score, 0);
        chk("hs2_new", new_record, 0);
`endif
        to_run();
        finish_round(8'd30);
        chk("hs3_final", final_score, 30);
`ifdef HISCORE_EN
        chk("hs3_high", high_score, 35);
`else
        chk("hs3_high", high_score, 0);
`endif
        chk("hs3_new", new_record, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
